// File: rtl/store_align_queue_if.sv
// store_align_queue_if: execute-side store request, memory-side write port and fault reporting
interface store_align_queue_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [ADDR_W-1:0] in_addr;
    logic [XLEN-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [XLEN-1:0]   out_wdata;
    logic [XLEN/8-1:0] out_be;
    logic              misalign;
    logic              illegal;
    logic [ADDR_W-1:0] fault_addr;
    logic [CW-1:0]     count;
    modport master (
        output flush, in_valid, in_inst, in_addr, in_data, out_ready,
        input  in_ready, out_valid, out_addr, out_wdata, out_be, misalign, illegal, fault_addr, count
    );
    modport slave (
        input  flush, in_valid, in_inst, in_addr, in_data, out_ready,
        output in_ready, out_valid, out_addr, out_wdata, out_be, misalign, illegal, fault_addr, count
    );
endinterface

// File: rtl/store_align_queue.sv
// store_align_queue: decodes stores into lane-aligned writes, traps bad ones, queues the rest in a FWFT FIFO
module store_align_queue #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input logic              clk,
    input logic              rst,
    store_align_queue_if.slave bus
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [ADDR_W-1:0] r_addr  [DEPTH];
    logic [XLEN-1:0]   r_wdata [DEPTH];
    logic [NB-1:0]     r_be    [DEPTH];
    logic [PW-1:0]     r_wr, r_rd;
    logic [CW-1:0]     r_count;
    logic              r_misalign, r_illegal;
    logic [ADDR_W-1:0] r_fault;
    logic [2:0]        w_f3;
    logic [OW-1:0]     w_off, w_amask;
    logic [3:0]        w_size;
    logic [NB-1:0]     w_bmask, w_be;
    logic [XLEN-1:0]   w_dmask, w_wdata;
    logic              w_fire, w_store, w_legal, w_misal, w_push, w_pop;
    assign bus.in_ready   = r_count != FULL;
    assign bus.out_valid  = r_count != '0;
    assign bus.out_addr   = r_addr[r_rd];
    assign bus.out_wdata  = r_wdata[r_rd];
    assign bus.out_be     = r_be[r_rd];
    assign bus.misalign   = r_misalign;
    assign bus.illegal    = r_illegal;
    assign bus.fault_addr = r_fault;
    assign bus.count      = r_count;
    // decode size/offset, build the lane mask and shifted data, classify the request
    always_comb begin
        w_f3    = bus.in_inst[14:12];
        w_off   = bus.in_addr[OW-1:0];
        w_size  = 4'd1 << w_f3[1:0];
        w_amask = OW'(w_size - 4'd1);
        w_bmask = NB'((16'd1 << w_size) - 16'd1);
        w_be    = w_bmask << w_off;
        w_dmask = '0;
        for (int b = 0; b < NB; b++) w_dmask[8*b +: 8] = {8{w_bmask[b]}};
        w_wdata = (bus.in_data & w_dmask) << {w_off, 3'b000};
        w_store = bus.in_inst[6:0] == 7'b0100011;
        w_legal = (w_f3 < 3'd3) || (w_f3 == 3'd3 && XLEN == 64);
        w_misal = (w_off & w_amask) != '0;
        w_fire  = bus.in_valid && bus.in_ready;
        w_push  = w_fire && w_store && w_legal && !w_misal && !bus.flush;
        w_pop   = bus.out_valid && bus.out_ready && !bus.flush;
    end
    // pointers, occupancy and fault pulses; flush clears the queue but not the fault report
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
            r_illegal  <= 1'b0;
            r_fault    <= '0;
        end else begin
            r_illegal  <= w_fire && w_store && !w_legal;
            r_misalign <= w_fire && w_store && w_legal && w_misal;
            if (w_fire && w_store && (!w_legal || w_misal)) r_fault <= bus.in_addr;
            if (bus.flush) begin
                r_wr    <= '0;
                r_rd    <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wr <= r_wr + 1'b1;
                if (w_pop) r_rd <= r_rd + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end
    // queue storage; the head entry drives the memory port directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
                r_be[i]    <= '0;
            end
        end else if (w_push) begin
            r_addr[r_wr]  <= {bus.in_addr[ADDR_W-1:OW], OW'(0)};
            r_wdata[r_wr] <= w_wdata;
            r_be[r_wr]    <= w_be;
        end
    end
endmodule

// File: tb/tb_store_align_queue.sv
// tb_store_align_queue: directed and randomized checks of the store queue against a behavioural model
module tb_store_align_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    store_align_queue_if #(.XLEN(32), .ADDR_W(32), .DEPTH(2)) a();
    store_align_queue_if #(.XLEN(64), .ADDR_W(32), .DEPTH(4)) b();
    store_align_queue #(.XLEN(32), .ADDR_W(32), .DEPTH(2)) u32 (.clk(clk), .rst(rst), .bus(a));
    store_align_queue #(.XLEN(64), .ADDR_W(32), .DEPTH(4)) u64 (.clk(clk), .rst(rst), .bus(b));
    typedef struct {logic [31:0] a; logic [63:0] w; logic [7:0] e;} ent_t;
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] st(input logic [2:0] f3);
        return {17'd0, f3, 5'd0, 7'h23};
    endfunction

    // kind: 0 not a store, 1 queued, 2 misaligned, 3 illegal
    function automatic void model(input int nb, input logic [31:0] inst, input logic [31:0] addr,
                                  input logic [63:0] data, output int kind, output ent_t e);
        int sz, off;
        logic [127:0] m, w;
        kind = 0; e.a = '0; e.w = '0; e.e = '0;
        if (inst[6:0] != 7'h23) return;
        if (int'(inst[14:12]) > (nb == 8 ? 3 : 2)) begin kind = 3; return; end
        sz = 1 << inst[14:12];
        off = int'(addr % nb);
        if (off % sz != 0) begin kind = 2; return; end
        kind = 1;
        e.a = addr - off;
        m = (128'd1 << (8 * sz)) - 1;
        w = ({64'd0, data} & m) << (8 * off);
        e.w = w[63:0];
        e.e = 8'(((1 << sz) - 1) << off);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a.flush = 0; a.in_valid = 0; a.in_inst = 0; a.in_addr = 0; a.in_data = 0; a.out_ready = 0;
        b.flush = 0; b.in_valid = 0; b.in_inst = 0; b.in_addr = 0; b.in_data = 0; b.out_ready = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick(); tick();
        checks++; if (a.count !== 2'd0 || a.out_valid !== 1'b0 || a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ctrl: count=%0d ov=%b ir=%b exp 0 0 1", a.count, a.out_valid, a.in_ready); end
        checks++; if (a.misalign !== 1'b0 || a.illegal !== 1'b0 || a.fault_addr !== 32'd0) begin errors++; $display("FAIL reset_fault: mis=%b ill=%b fa=%h exp 0 0 0", a.misalign, a.illegal, a.fault_addr); end
        checks++; if (a.out_addr !== 32'd0 || a.out_wdata !== 32'd0 || a.out_be !== 4'd0) begin errors++; $display("FAIL reset_data: addr=%h wd=%h be=%b exp 0", a.out_addr, a.out_wdata, a.out_be); end
        checks++; if (b.count !== 3'd0 || b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_b: count=%0d ov=%b exp 0 0", b.count, b.out_valid); end
        rst = 0;
        tick();
    endtask

    task automatic test_sb();
        a.in_valid = 1; a.in_inst = st(3'd0); a.in_addr = 32'h1003; a.in_data = 32'h0000_00AB;
        tick();
        a.in_valid = 0;
        checks++; if (a.out_valid !== 1'b1 || a.count !== 2'd1) begin errors++; $display("FAIL sb_valid: ov=%b count=%0d exp 1 1", a.out_valid, a.count); end
        checks++; if (a.out_addr !== 32'h1000 || a.out_be !== 4'b1000 || a.out_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL sb_data: addr=%h be=%b wd=%h exp 1000 1000 ab000000", a.out_addr, a.out_be, a.out_wdata); end
        a.out_ready = 1;
        tick();
        a.out_ready = 0;
        checks++; if (a.count !== 2'd0 || a.out_valid !== 1'b0) begin errors++; $display("FAIL sb_drain: count=%0d ov=%b exp 0 0", a.count, a.out_valid); end
    endtask

    task automatic test_misalign();
        a.in_valid = 1; a.in_inst = st(3'd1); a.in_addr = 32'h1001; a.in_data = 32'h1234;
        tick();
        a.in_valid = 0;
        checks++; if (a.misalign !== 1'b1 || a.illegal !== 1'b0 || a.fault_addr !== 32'h1001 || a.count !== 2'd0) begin errors++; $display("FAIL sh_mis: mis=%b ill=%b fa=%h count=%0d exp 1 0 1001 0", a.misalign, a.illegal, a.fault_addr, a.count); end
        tick();
        checks++; if (a.misalign !== 1'b0 || a.fault_addr !== 32'h1001) begin errors++; $display("FAIL sh_pulse: mis=%b fa=%h exp 0 1001", a.misalign, a.fault_addr); end
    endtask

    task automatic test_illegal();
        a.in_valid = 1; a.in_inst = st(3'd3); a.in_addr = 32'h2000; a.in_data = 32'h55;
        tick();
        a.in_valid = 0;
        checks++; if (a.illegal !== 1'b1 || a.misalign !== 1'b0 || a.fault_addr !== 32'h2000 || a.count !== 2'd0) begin errors++; $display("FAIL sd32_ill: ill=%b mis=%b fa=%h count=%0d exp 1 0 2000 0", a.illegal, a.misalign, a.fault_addr, a.count); end
        a.in_valid = 1; a.in_inst = st(3'd5); a.in_addr = 32'h2003;
        tick();
        a.in_valid = 0;
        checks++; if (a.illegal !== 1'b1 || a.misalign !== 1'b0 || a.fault_addr !== 32'h2003) begin errors++; $display("FAIL f3_5_ill: ill=%b mis=%b fa=%h exp 1 0 2003", a.illegal, a.misalign, a.fault_addr); end
        a.in_valid = 1; a.in_inst = 32'h0000_0013; a.in_addr = 32'h3001;
        tick();
        a.in_valid = 0;
        checks++; if (a.illegal !== 1'b0 || a.misalign !== 1'b0 || a.count !== 2'd0 || a.fault_addr !== 32'h2003) begin errors++; $display("FAIL nonstore: ill=%b mis=%b count=%0d fa=%h exp 0 0 0 2003", a.illegal, a.misalign, a.count, a.fault_addr); end
    endtask

    task automatic test_sd64();
        b.in_valid = 1; b.in_inst = st(3'd3); b.in_addr = 32'h2008; b.in_data = 64'h1122_3344_5566_7788;
        tick();
        b.in_valid = 0;
        checks++; if (b.out_valid !== 1'b1 || b.out_be !== 8'hFF || b.out_wdata !== 64'h1122_3344_5566_7788 || b.out_addr !== 32'h2008) begin errors++; $display("FAIL sd64: ov=%b be=%h wd=%h addr=%h exp 1 ff 1122334455667788 2008", b.out_valid, b.out_be, b.out_wdata, b.out_addr); end
        b.out_ready = 1;
        tick();
        b.out_ready = 0;
    endtask

    task automatic test_random64();
        int kind, r;
        ent_t e;
        logic [31:0] ef = 0;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            b.in_inst = (r == 0) ? {$urandom} & 32'hFFFF_FF80 | 32'h13 : st(3'($urandom_range(0, r < 8 ? 3 : 7)));
            b.in_addr = $urandom; b.in_data = {$urandom, $urandom}; b.in_valid = 1;
            model(8, b.in_inst, b.in_addr, b.in_data, kind, e);
            if (kind >= 2) ef = b.in_addr;
            tick();
            b.in_valid = 0;
            checks++; if (b.misalign !== (kind == 2) || b.illegal !== (kind == 3) || b.fault_addr !== ef) begin errors++; $display("FAIL r64_fault: mis=%b ill=%b fa=%h exp kind %0d fa %h", b.misalign, b.illegal, b.fault_addr, kind, ef); end
            checks++; if (b.count !== 3'(kind == 1)) begin errors++; $display("FAIL r64_count: got %0d exp %0d", b.count, kind == 1); end
            if (kind == 1) begin
                checks++; if (b.out_addr !== e.a || b.out_wdata !== e.w || b.out_be !== e.e) begin errors++; $display("FAIL r64_data: addr=%h wd=%h be=%h exp %h %h %h", b.out_addr, b.out_wdata, b.out_be, e.a, e.w, e.e); end
                b.out_ready = 1;
                tick();
                b.out_ready = 0;
            end
        end
    endtask

    task automatic test_back_to_back();
        a.out_ready = 0; a.in_valid = 1; a.in_inst = st(3'd2);
        a.in_addr = 32'h10; a.in_data = 32'h1111_1111;
        tick();
        a.in_addr = 32'h14; a.in_data = 32'h2222_2222;
        tick();
        checks++; if (a.in_ready !== 1'b0 || a.count !== 2'd2) begin errors++; $display("FAIL full: ir=%b count=%0d exp 0 2", a.in_ready, a.count); end
        a.in_addr = 32'h18; a.in_data = 32'h3333_3333;
        tick();
        checks++; if (a.count !== 2'd2 || a.out_addr !== 32'h10 || a.out_wdata !== 32'h1111_1111) begin errors++; $display("FAIL full_hold: count=%0d addr=%h wd=%h exp 2 10 11111111", a.count, a.out_addr, a.out_wdata); end
        a.out_ready = 1;
        tick();
        checks++; if (a.count !== 2'd1 || a.out_addr !== 32'h14 || a.in_ready !== 1'b1) begin errors++; $display("FAIL pop_no_bypass: count=%0d addr=%h ir=%b exp 1 14 1", a.count, a.out_addr, a.in_ready); end
        tick();
        a.in_valid = 0;
        checks++; if (a.count !== 2'd1 || a.out_addr !== 32'h18 || a.out_wdata !== 32'h3333_3333) begin errors++; $display("FAIL push_pop: count=%0d addr=%h wd=%h exp 1 18 33333333", a.count, a.out_addr, a.out_wdata); end
        tick();
        a.out_ready = 0;
        checks++; if (a.count !== 2'd0 || a.out_valid !== 1'b0) begin errors++; $display("FAIL drain: count=%0d ov=%b exp 0 0", a.count, a.out_valid); end
    endtask

    task automatic test_flush();
        a.in_valid = 1; a.in_inst = st(3'd2); a.in_addr = 32'h20;
        tick();
        a.in_addr = 32'h24;
        tick();
        a.in_addr = 32'h28; a.flush = 1; a.out_ready = 1;
        tick();
        checks++; if (a.count !== 2'd0 || a.out_valid !== 1'b0) begin errors++; $display("FAIL flush_full: count=%0d ov=%b exp 0 0", a.count, a.out_valid); end
        a.in_addr = 32'h30;
        tick();
        checks++; if (a.count !== 2'd0 || a.out_valid !== 1'b0) begin errors++; $display("FAIL flush_push: count=%0d ov=%b exp 0 0", a.count, a.out_valid); end
        a.in_inst = st(3'd1); a.in_addr = 32'h31;
        tick();
        checks++; if (a.misalign !== 1'b1 || a.fault_addr !== 32'h31 || a.count !== 2'd0) begin errors++; $display("FAIL flush_pulse: mis=%b fa=%h count=%0d exp 1 31 0", a.misalign, a.fault_addr, a.count); end
        idle();
    endtask

    task automatic test_async_rst();
        a.in_valid = 1; a.in_inst = st(3'd0); a.in_addr = 32'h40;
        tick();
        a.in_addr = 32'h41;
        tick();
        a.in_valid = 0; a.out_ready = 1;
        tick();
        checks++; if (a.count !== 2'd1 || a.out_addr !== 32'h40) begin errors++; $display("FAIL pre_rst: count=%0d addr=%h exp 1 40", a.count, a.out_addr); end
        #2 rst = 1;
        #1;
        checks++; if (a.count !== 2'd0 || a.out_valid !== 1'b0) begin errors++; $display("FAIL async_rst: count=%0d ov=%b exp 0 0", a.count, a.out_valid); end
        tick();
        idle();
        rst = 0;
        tick();
        checks++; if (a.count !== 2'd0 || a.misalign !== 1'b0 || a.illegal !== 1'b0 || a.fault_addr !== 32'd0) begin errors++; $display("FAIL post_rst: count=%0d mis=%b ill=%b fa=%h exp 0", a.count, a.misalign, a.illegal, a.fault_addr); end
    endtask

    task automatic test_random32();
        ent_t q[$];
        ent_t e;
        int kind, r;
        logic fire, pop, em = 0, ei = 0;
        logic [31:0] ef = 0;
        for (int i = 0; i < 2000; i++) begin
            checks++; if (a.count !== 2'(q.size()) || a.in_ready !== (q.size() < 2) || a.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL r32_ctrl: count=%0d ir=%b ov=%b exp count %0d", a.count, a.in_ready, a.out_valid, q.size()); end
            checks++; if (a.misalign !== em || a.illegal !== ei || a.fault_addr !== ef) begin errors++; $display("FAIL r32_fault: mis=%b ill=%b fa=%h exp %b %b %h", a.misalign, a.illegal, a.fault_addr, em, ei, ef); end
            if (q.size() != 0) begin
                checks++; if (a.out_addr !== q[0].a || a.out_wdata !== q[0].w[31:0] || a.out_be !== q[0].e[3:0]) begin errors++; $display("FAIL r32_head: addr=%h wd=%h be=%b exp %h %h %b", a.out_addr, a.out_wdata, a.out_be, q[0].a, q[0].w[31:0], q[0].e[3:0]); end
            end
            r = $urandom_range(0, 9);
            a.in_inst = (r == 0) ? {$urandom} & 32'hFFFF_FF80 | 32'h13 : st(3'($urandom_range(0, r < 8 ? 2 : 7)));
            a.in_addr = $urandom; a.in_data = $urandom;
            a.in_valid = $urandom_range(0, 3) != 0;
            a.out_ready = $urandom_range(0, 2) != 0;
            a.flush = $urandom_range(0, 24) == 0;
            model(4, a.in_inst, a.in_addr, {32'd0, a.in_data}, kind, e);
            fire = a.in_valid && q.size() < 2;
            pop = q.size() != 0 && a.out_ready;
            em = fire && kind == 2;
            ei = fire && kind == 3;
            if (em || ei) ef = a.in_addr;
            if (a.flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (fire && kind == 1) q.push_back(e);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_sb();
        test_misalign();
        test_illegal();
        test_sd64();
        test_random64();
        test_back_to_back();
        test_flush();
        test_async_rst();
        test_random32();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
